// File: rtl/wb_slave_timeout_guard.sv
// Wishbone classic slave guard: passes transfers through, aborts with err when the peripheral misses its ack budget.
// Optional status outputs (abort count, last aborted address) enabled by `define WB_TIMEOUT_STATUS_EN.
module wb_slave_timeout_guard #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  m_wb_cyc_i,
  input  logic                  m_wb_stb_i,
  input  logic                  m_wb_we_i,
  input  logic [SEL_WIDTH-1:0]  m_wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] m_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m_wb_dat_o,
  output logic                  m_wb_ack_o,
  output logic                  m_wb_err_o,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic                  s_wb_ack_i,
  input  logic                  s_wb_err_i,
  output logic                  timeout_o
`ifdef WB_TIMEOUT_STATUS_EN
  ,
  output logic [7:0]            to_count_o,
  output logic [ADDR_WIDTH-1:0] to_addr_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ABORT} state_t;

  // The counter holds the number of request cycles already spent without a
  // termination, so the last allowed cycle is seen when it equals TIMEOUT-1.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 req, term, abort;

  assign req   = m_wb_cyc_i & m_wb_stb_i;
  assign term  = s_wb_ack_i | s_wb_err_i;
  assign abort = (state == ST_ABORT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req && !term) begin
          if (TIMEOUT_CYCLES == 1) begin
            state_nxt = ST_ABORT;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_WIDTH'(1);
          end
        end
      end
      ST_WAIT: begin
        if (term || !req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST_CNT) begin
          state_nxt = ST_ABORT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Terminations stay combinational outside ABORT so zero-wait slaves keep zero wait.
  assign s_wb_cyc_o = m_wb_cyc_i & ~abort & ~wb_rst_i;
  assign s_wb_stb_o = m_wb_stb_i & ~abort & ~wb_rst_i;
  assign s_wb_we_o  = m_wb_we_i;
  assign s_wb_sel_o = m_wb_sel_i;
  assign s_wb_adr_o = m_wb_adr_i;
  assign s_wb_dat_o = m_wb_dat_i;

  assign m_wb_ack_o = s_wb_ack_i & ~abort & ~wb_rst_i;
  assign m_wb_err_o = abort | (s_wb_err_i & ~wb_rst_i);
  assign m_wb_dat_o = (abort || wb_rst_i) ? '0 : s_wb_dat_i;
  assign timeout_o  = abort;

`ifdef WB_TIMEOUT_STATUS_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_count_o <= '0;
      to_addr_o  <= '0;
    end else if (state_nxt == ST_ABORT && state != ST_ABORT) begin
      if (to_count_o != 8'hFF) to_count_o <= to_count_o + 8'd1;
      to_addr_o <= m_wb_adr_i;
    end
  end
`endif

endmodule

// File: tb/tb_wb_slave_timeout_guard.sv
// Self-checking bench for wb_slave_timeout_guard with a 16-cycle ack budget.
`timescale 1ns/1ps
module tb_wb_slave_timeout_guard;
  localparam int T = 16;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m_wb_cyc_i = 0, m_wb_stb_i = 0, m_wb_we_i = 0;
  logic [3:0]  m_wb_sel_i = 4'hF;
  logic [31:0] m_wb_adr_i = 0, m_wb_dat_i = 0;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_ack_o, m_wb_err_o;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [3:0]  s_wb_sel_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o;
  logic [31:0] s_wb_dat_i = 0;
  logic        s_wb_ack_i = 0, s_wb_err_i = 0;
  logic        timeout_o;
`ifdef WB_TIMEOUT_STATUS_EN
  logic [7:0]  to_count_o;
  logic [31:0] to_addr_o;
`endif

  wb_slave_timeout_guard #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYCLES(T), .CNT_WIDTH(8)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_wb_cyc_i(m_wb_cyc_i), .m_wb_stb_i(m_wb_stb_i), .m_wb_we_i(m_wb_we_i),
    .m_wb_sel_i(m_wb_sel_i), .m_wb_adr_i(m_wb_adr_i), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_ack_o(m_wb_ack_o), .m_wb_err_o(m_wb_err_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_sel_o(s_wb_sel_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i),
    .timeout_o(timeout_o)
`ifdef WB_TIMEOUT_STATUS_EN
    , .to_count_o(to_count_o), .to_addr_o(to_addr_o)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 = master dropped, 1 = ack, 2 = slave err, 3 = timeout
  task automatic run_txn(input int ack_at, input int serr_at, input int drop_at,
                         input logic [31:0] rdata, input logic [31:0] adr,
                         output int kind, output int cyc_at, output logic [31:0] dat,
                         output int bad);
    logic act;
    kind = 0; cyc_at = 0; dat = '0; bad = 0;
    for (int c = 1; c <= T + 4; c++) begin
      @(posedge wb_clk_i); #2;
      act = (drop_at == 0) || (c < drop_at);
      m_wb_cyc_i = act; m_wb_stb_i = act; m_wb_adr_i = adr; s_wb_dat_i = rdata;
      s_wb_ack_i = act && (c == ack_at);
      s_wb_err_i = act && (c == serr_at);
      #2;
      if (timeout_o) begin
        kind = 3; cyc_at = c; dat = m_wb_dat_o;
        if (!m_wb_err_o || m_wb_ack_o || s_wb_stb_o || s_wb_cyc_o) bad++;
        break;
      end
      if (s_wb_stb_o != act || s_wb_adr_o != adr) bad++;
      if (m_wb_ack_o) begin kind = 1; cyc_at = c; dat = m_wb_dat_o; break; end
      if (m_wb_err_o) begin kind = 2; cyc_at = c; dat = m_wb_dat_o; break; end
      if (!act) begin cyc_at = c; break; end
    end
    @(posedge wb_clk_i); #2;
    m_wb_cyc_i = 0; m_wb_stb_i = 0; s_wb_ack_i = 0; s_wb_err_i = 0;
    #2;
    if (s_wb_cyc_o || s_wb_stb_o || m_wb_ack_o || m_wb_err_o || timeout_o) bad++;
  endtask

  // Reference: earliest termination inside the budget while the request is up;
  // otherwise the master's drop, otherwise an abort right after the budget.
  task automatic model(input int ack_at, input int serr_at, input int drop_at,
                       output int kind, output int cyc_at);
    int last_live;
    last_live = (drop_at == 0) ? T : ((drop_at - 1 < T) ? drop_at - 1 : T);
    kind = -1; cyc_at = 0;
    if (ack_at >= 1 && ack_at <= last_live) begin kind = 1; cyc_at = ack_at; end
    if (serr_at >= 1 && serr_at <= last_live && (kind < 0 || serr_at < cyc_at)) begin
      kind = 2; cyc_at = serr_at;
    end
    if (kind < 0) begin
      if (drop_at != 0 && drop_at <= T) begin kind = 0; cyc_at = drop_at; end
      else begin kind = 3; cyc_at = T + 1; end
    end
  endtask

  typedef struct {
    int          ack_at;
    int          serr_at;
    int          drop_at;
    logic [31:0] rdata;
    int          exp_kind;
    int          exp_cyc;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int kind, cyc, bad, ekind, ecyc, nerr, first_err, second_err;
    logic [31:0] dat, rd;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, cyc, bad, ekind, ecyc, nerr, first_err, second_err;
    int a, e, d;
    logic [31:0] dat, rd;

    vecs[0] = '{3,  0, 0,  32'hA5A5_0001, 1, 3,  32'hA5A5_0001};
    vecs[1] = '{0,  0, 0,  32'h1111_2222, 3, 17, 32'h0};
    vecs[2] = '{16, 0, 0,  32'h0BAD_F00D, 1, 16, 32'h0BAD_F00D};
    vecs[3] = '{17, 0, 0,  32'h3333_4444, 3, 17, 32'h0};
    vecs[4] = '{1,  0, 0,  32'h5555_6666, 1, 1,  32'h5555_6666};
    vecs[5] = '{0,  7, 0,  32'h7777_8888, 2, 7,  32'h7777_8888};
    vecs[6] = '{0,  0, 5,  32'h9999_AAAA, 0, 5,  32'h0};
    vecs[7] = '{0,  0, 0,  32'hBBBB_CCCC, 3, 17, 32'h0};
    vecs[8] = '{0,  0, 17, 32'hDDDD_EEEE, 3, 17, 32'h0};

    // reset state with live peripheral data that must not leak through
    s_wb_dat_i = 32'hDEAD_BEEF;
    s_wb_ack_i = 1'b1;
    #1;
    check("reset_ack", m_wb_ack_o, 0);
    check("reset_err", m_wb_err_o, 0);
    check("reset_dat", m_wb_dat_o, 0);
    check("reset_timeout", timeout_o, 0);
    check("reset_s_cyc", s_wb_cyc_o, 0);
    repeat (2) @(posedge wb_clk_i);
    #2; s_wb_ack_i = 0; wb_rst_i = 0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].ack_at, vecs[i].serr_at, vecs[i].drop_at, vecs[i].rdata,
              32'h1000_0000 + i, kind, cyc, dat, bad);
      check($sformatf("vec%0d_kind", i), kind, vecs[i].exp_kind);
      check($sformatf("vec%0d_cycle", i), cyc, vecs[i].exp_cyc);
      if (vecs[i].exp_kind != 0)
        check($sformatf("vec%0d_dat", i), dat, vecs[i].exp_dat);
      check($sformatf("vec%0d_protocol", i), bad, 0);
    end

    // stb held through an abort restarts with a full budget
    nerr = 0; first_err = 0; second_err = 0;
    for (int c = 1; c <= 2 * (T + 1); c++) begin
      @(posedge wb_clk_i); #2;
      m_wb_cyc_i = 1; m_wb_stb_i = 1; s_wb_ack_i = 0; s_wb_err_i = 0;
      #2;
      if (m_wb_err_o) begin
        nerr++;
        if (first_err == 0) first_err = c; else if (second_err == 0) second_err = c;
      end
    end
    @(posedge wb_clk_i); #2; m_wb_cyc_i = 0; m_wb_stb_i = 0;
    check("held_stb_err_count", nerr, 2);
    check("held_stb_first_err", first_err, T + 1);
    check("held_stb_second_err", second_err, 2 * (T + 1));

    // randomized transfers against the reference
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 20);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      if (e == a) e = 0;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 18) : 0;
      rd = $urandom;
      model(a, e, d, ekind, ecyc);
      run_txn(a, e, d, rd, $urandom, kind, cyc, dat, bad);
      check($sformatf("rnd%0d_kind", n), kind, ekind);
      check($sformatf("rnd%0d_cycle", n), cyc, ecyc);
      if (ekind == 1) check($sformatf("rnd%0d_dat", n), dat, rd);
      if (ekind == 3) check($sformatf("rnd%0d_dat", n), dat, 0);
      check($sformatf("rnd%0d_protocol", n), bad, 0);
    end

    // asynchronous reset in cycle 10 of a hung transfer
    for (int c = 1; c <= 10; c++) begin
      @(posedge wb_clk_i); #2;
      m_wb_cyc_i = 1; m_wb_stb_i = 1; s_wb_dat_i = 32'hCAFE_0000;
    end
    wb_rst_i = 1;
    #1;
    check("arst_err", m_wb_err_o, 0);
    check("arst_timeout", timeout_o, 0);
    check("arst_dat", m_wb_dat_o, 0);
    check("arst_s_stb", s_wb_stb_o, 0);
    @(posedge wb_clk_i); #2; m_wb_cyc_i = 0; m_wb_stb_i = 0;
    @(posedge wb_clk_i); #2; wb_rst_i = 0;
    nerr = 0;
    for (int c = 0; c < T + 4; c++) begin
      @(posedge wb_clk_i); #4;
      if (m_wb_err_o || timeout_o) nerr++;
    end
    check("post_reset_no_err", nerr, 0);
    run_txn(4, 0, 0, 32'h600D_0004, 32'h2000_0000, kind, cyc, dat, bad);
    check("post_reset_kind", kind, 1);
    check("post_reset_cycle", cyc, 4);
    check("post_reset_dat", dat, 32'h600D_0004);

`ifdef WB_TIMEOUT_STATUS_EN
    check("status_after_reset", to_count_o, 0);
    for (int i = 0; i < 257; i++) begin
      run_txn(0, 0, 0, $urandom, (i == 256) ? 32'h3000_0010 : $urandom, kind, cyc, dat, bad);
      if (i == 0) check("status_count_one", to_count_o, 1);
    end
    check("status_count_sat", to_count_o, 255);
    check("status_addr", to_addr_o, 32'h3000_0010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
